// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch unit.
package fetch_pkg;

  localparam int unsigned XLEN       = 32;
  localparam int unsigned INST_BYTES = 4;
  localparam logic [XLEN-1:0] NOP_INST = 32'h00000013;

  typedef enum logic [1:0] {
    FS_FETCH = 2'd0,
    FS_WAIT  = 2'd1,
    FS_DRAIN = 2'd2
  } fetch_state_e;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] inst;
  } fetch_entry_t;

  // Clear the byte-offset bits so the address points at an instruction word.
  function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] addr);
    return addr & ~XLEN'(INST_BYTES - 1);
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous instruction buffer with push, pop and flush; a full buffer
// accepts a push in the same cycle it is popped.
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int unsigned DEPTH = 2
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         push,
  input  fetch_entry_t push_data,
  input  logic         pop,
  input  logic         flush,
  output fetch_entry_t head,
  output logic         full,
  output logic         empty,
  output logic         full_next_c
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

  fetch_entry_t     mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;
  logic [CNT_W-1:0] count_n;
  logic             do_push;
  logic             do_pop;

  assign full        = (count == CNT_W'(DEPTH));
  assign empty       = (count == '0);
  assign do_pop      = pop && !empty;
  assign do_push     = push && (!full || do_pop);
  assign head        = mem[rd_ptr];
  assign full_next_c = (count_n == CNT_W'(DEPTH));

  always_comb begin
    count_n = count;
    if (flush) begin
      count_n = '0;
    end else begin
      case ({do_push, do_pop})
        2'b10:   count_n = count + CNT_W'(1);
        2'b01:   count_n = count - CNT_W'(1);
        default: count_n = count;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      count <= count_n;
      if (flush) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
      end else begin
        if (do_push) begin
          mem[wr_ptr] <= push_data;
          wr_ptr      <= wr_ptr + PTR_W'(1);
        end
        if (do_pop) rd_ptr <= rd_ptr + PTR_W'(1);
      end
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch unit: one outstanding memory request at a time, results
// buffered for decode, with redirect flush and stale-response draining.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = 32'h00000000,
  parameter int unsigned BUF_DEPTH = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        imem_req_valid,
  output logic [31:0] imem_req_addr,
  input  logic        imem_req_ready,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  output logic        inst_valid,
  output logic [31:0] inst_data,
  output logic [31:0] inst_pc,
  input  logic        inst_ready
);

  fetch_state_e    state;
  fetch_state_e    state_n;
  logic [XLEN-1:0] fpc;
  logic [XLEN-1:0] fpc_n;
  logic            req_valid_q;
  logic            req_valid_n;
  logic            req_fire;
  logic            rsp_push;
  logic            buf_pop;
  logic            buf_empty;
  logic            buf_full;
  logic            buf_full_next;
  fetch_entry_t    push_entry;
  fetch_entry_t    head;

  assign imem_req_valid = req_valid_q;
  assign imem_req_addr  = fpc;
  assign req_fire       = req_valid_q && imem_req_ready && !buf_full;
  assign buf_pop        = !buf_empty && inst_ready && !redirect_valid;
  // fpc has already advanced past the outstanding request while in WAIT.
  assign push_entry     = {fpc - XLEN'(INST_BYTES), imem_rsp_data};
  assign inst_valid     = !buf_empty;
  assign inst_data      = head.inst;
  assign inst_pc        = head.pc;

  always_comb begin
    state_n  = state;
    fpc_n    = fpc;
    rsp_push = 1'b0;
    case (state)
      FS_FETCH: begin
        if (req_fire) begin
          fpc_n   = fpc + XLEN'(INST_BYTES);
          state_n = redirect_valid ? FS_DRAIN : FS_WAIT;
        end
      end
      FS_WAIT: begin
        if (imem_rsp_valid) begin
          rsp_push = 1'b1;
          state_n  = FS_FETCH;
        end else if (redirect_valid) begin
          state_n = FS_DRAIN;
        end
      end
      FS_DRAIN: begin
        if (imem_rsp_valid) state_n = FS_FETCH;
      end
      default: state_n = FS_FETCH;
    endcase
    if (redirect_valid) fpc_n = word_align(redirect_pc);
    // A request is only offered when its response is guaranteed a slot.
    req_valid_n = (state_n == FS_FETCH) && !buf_full_next;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= FS_FETCH;
      fpc         <= RESET_PC;
      req_valid_q <= 1'b0;
    end else begin
      state       <= state_n;
      fpc         <= fpc_n;
      req_valid_q <= req_valid_n;
    end
  end

  fetch_fifo #(
    .DEPTH (BUF_DEPTH)
  ) u_fifo (
    .clk         (clk),
    .reset       (reset),
    .push        (rsp_push),
    .push_data   (push_entry),
    .pop         (buf_pop),
    .flush       (redirect_valid),
    .head        (head),
    .full        (buf_full),
    .empty       (buf_empty),
    .full_next_c (buf_full_next)
  );

endmodule
